mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Parametrised memory-interface sequencer that replaces the fixed MAR/MDR load/gate scheme.
- It sits between the control FSM/datapath and an asynchronous SRAM.
- It accepts word or byte requests over a valid/ready handshake and generates chip-enable, output-enable, write-enable and byte-lane strobes with a configurable number of wait states.
- It returns read data with an explicit response pulse, so control no longer counts memory cycles.

Parameters:
DATA_W, 16, data width in bits; must be even, two byte lanes of DATA_W/2.
ADDR_W, 20, byte-address width of requests.
WAIT_CYCLES, 2, extra access cycles beyond the minimum; legal range 0..15.

Ports:
Clk  in  1  system clock, all state updates on rising edge
Reset  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  unit can accept a request this cycle
req_write  in  1  1 = write, 0 = read
req_byte  in  1  1 = byte access, 0 = word access
req_addr  in  ADDR_W  byte address
req_wdata  in  DATA_W  write data; byte writes use bits [DATA_W/2-1:0]
resp_valid  out  1  one-cycle pulse, transaction complete
resp_err  out  1  qualifies resp_valid; misaligned word access
resp_rdata  out  DATA_W  read data, valid with resp_valid
mem_addr  out  ADDR_W  word address to SRAM, {1'b0, req_addr[ADDR_W-1:1]}
mem_ce_n  out  1  chip enable, active low
mem_oe_n  out  1  output enable, active low
mem_we_n  out  1  write enable, active low
mem_ub_n  out  1  upper byte lane enable, active low
mem_lb_n  out  1  lower byte lane enable, active low
mem_wdata  out  DATA_W  write data to the external tri-state driver
mem_drive  out  1  enables the external tri-state driver onto the SRAM data bus
mem_rdata  in  DATA_W  SRAM read data

Behaviour:
- Reset (synchronous, active-high; takes effect at the next rising edge of Clk):
  - State returns to IDLE and the wait counter clears.
  - req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0.
  - mem_ce_n=mem_oe_n=mem_we_n=mem_ub_n=mem_lb_n=1, mem_drive=0, mem_addr=0, mem_wdata=0.
  - Reset mid-transaction abandons the transaction, emits no response and deasserts all strobes.
- All outputs are registered.
- States: IDLE, SETUP, ACCESS, DONE.
- IDLE:
  - req_ready=1 in IDLE only.
  - On req_valid&&req_ready the unit latches addr, write, byte and wdata.
  - A word request with req_addr[0]=1 goes to DONE with resp_err=1, makes no memory cycle and returns resp_rdata=0.
  - Any other request goes to SETUP.
- SETUP (1 cycle):
  - mem_addr is driven and mem_ce_n=0.
  - Lane enables: word access drives both lanes low; byte access with addr[0]=0 drives mem_lb_n=0; byte access with addr[0]=1 drives mem_ub_n=0.
  - mem_oe_n and mem_we_n stay 1.
  - For writes, mem_drive=1 from SETUP through the last ACCESS cycle.
- ACCESS (WAIT_CYCLES+1 cycles):
  - Reads assert mem_oe_n=0; writes assert mem_we_n=0.
  - A down-counter loaded with WAIT_CYCLES in SETUP decrements each cycle; the last ACCESS cycle is counter==0.
  - Reads capture mem_rdata on that edge. Then go to DONE.
- DONE (1 cycle):
  - resp_valid=1; all strobes deasserted; mem_drive=0.
  - Next state is IDLE; req_ready returns 1 in the cycle after DONE.
- Latency: accept edge at cycle 0 gives resp_valid in cycle WAIT_CYCLES+3; with the default, cycle 5. The misaligned-error path gives resp_valid in cycle 1.
- Read data formatting:
  - Word read returns mem_rdata unchanged.
  - Byte read returns the addressed lane zero-extended in resp_rdata[DATA_W/2-1:0]. Sign extension is the datapath's job.
- Write data formatting:
  - Word write drives mem_wdata=wdata.
  - Byte write replicates wdata[DATA_W/2-1:0] onto both lanes; only the addressed lane's enable is low.
- req_valid while busy: ignored; the requester holds it until req_ready. No queueing.
- Back-to-back requests: minimum spacing is one IDLE cycle between DONE and the next accept.
- resp_rdata holds its value until the next completion; resp_err clears at the next DONE.

Decomposition:
- Shared package lc3b_types gets:
  - mem_state_t enum {IDLE, SETUP, ACCESS, DONE};
  - constant MEM_WAIT_W = 4;
  - a typedef for the byte-lane select.
- One sub-module, wait_counter: a loadable down-counter of width MEM_WAIT_W with a zero flag.

Test Plan:
- Reset asserted mid-ACCESS of a read -> next cycle all strobes=1, mem_drive=0, req_ready=1, no resp_valid ever emitted.
- Word read at addr 0x00010, WAIT_CYCLES=2, mem_rdata=0xBEEF -> mem_addr=0x00008, oe_n low for 3 cycles, resp_valid in cycle 5 with resp_rdata=0xBEEF, resp_err=0.
- Byte write to addr 0x00021, wdata=0x12AB -> mem_wdata=0xABAB, mem_ub_n=0, mem_lb_n=1, we_n low for 3 cycles, mem_drive high over SETUP+ACCESS only.
- Byte read at addr 0x00020, mem_rdata=0x80F7 -> resp_rdata=0x00F7. The same request at 0x00021 -> resp_rdata=0x0080.
- Word read at odd addr 0x00003 -> resp_valid in cycle 1 with resp_err=1, resp_rdata=0, mem_ce_n never low.
- WAIT_CYCLES=0 build: back-to-back reads with req_valid held high -> each response in cycle 3 after its accept, accepts spaced 4 cycles apart, req_ready low during SETUP/ACCESS/DONE.

Source files
------------

// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - shared types for the SRAM access sequencer
package lc3b_types;

  localparam int MEM_WAIT_W = 4;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} mem_state_t;

  // Bit 1 = upper lane, bit 0 = lower lane; a set bit means the lane is enabled.
  typedef enum logic [1:0] {
    LANE_NONE = 2'b00,
    LANE_LO   = 2'b01,
    LANE_HI   = 2'b10,
    LANE_BOTH = 2'b11
  } lane_sel_t;

  function automatic lane_sel_t lane_select(input logic is_byte, input logic addr_lsb);
    if (!is_byte) return LANE_BOTH;
    return addr_lsb ? LANE_HI : LANE_LO;
  endfunction

endpackage

// File: rtl/wait_counter.sv
// rtl/wait_counter.sv - loadable down-counter with zero flag for SRAM wait states
module wait_counter
  import lc3b_types::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [MEM_WAIT_W-1:0] load_val,
  input  logic                  dec,
  output logic                  zero
);

  logic [MEM_WAIT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && !zero) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - request/response sequencer driving an asynchronous SRAM
module mem_access_unit
  import lc3b_types::*;
#(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 20,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_byte,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_ce_n,
  output logic              mem_oe_n,
  output logic              mem_we_n,
  output logic              mem_ub_n,
  output logic              mem_lb_n,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_drive,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int HALF_W = DATA_W / 2;

  mem_state_t        state, next_state;
  logic              write_q, byte_q, addr_lsb_q;
  logic              accept, misaligned, wait_zero;
  logic              nxt_write, nxt_active;
  lane_sel_t         nxt_lane;
  logic [DATA_W-1:0] rdata_fmt, wdata_fmt;

  assign accept     = req_valid && (state == IDLE);
  assign misaligned = !req_byte && req_addr[0];

  wait_counter u_wait (
    .clk      (Clk),
    .rst      (Reset),
    .load     (state == SETUP),
    .load_val (MEM_WAIT_W'(WAIT_CYCLES)),
    .dec      (state == ACCESS),
    .zero     (wait_zero)
  );

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (req_valid) next_state = misaligned ? DONE : SETUP;
      SETUP:   next_state = ACCESS;
      ACCESS:  if (wait_zero) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs are registered from the upcoming state, so the accept cycle must
  // use the live request fields rather than the not-yet-latched copies.
  always_comb begin
    nxt_write  = accept ? req_write : write_q;
    nxt_lane   = accept ? lane_select(req_byte, req_addr[0]) : lane_select(byte_q, addr_lsb_q);
    nxt_active = (next_state == SETUP) || (next_state == ACCESS);
    wdata_fmt  = req_byte ? {2{req_wdata[HALF_W-1:0]}} : req_wdata;
    rdata_fmt  = mem_rdata;
    if (byte_q) begin
      rdata_fmt = {{HALF_W{1'b0}}, addr_lsb_q ? mem_rdata[DATA_W-1:HALF_W] : mem_rdata[HALF_W-1:0]};
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      write_q    <= 1'b0;
      byte_q     <= 1'b0;
      addr_lsb_q <= 1'b0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_ce_n   <= 1'b1;
      mem_oe_n   <= 1'b1;
      mem_we_n   <= 1'b1;
      mem_ub_n   <= 1'b1;
      mem_lb_n   <= 1'b1;
      mem_drive  <= 1'b0;
    end else begin
      state <= next_state;
      if (accept) begin
        write_q    <= req_write;
        byte_q     <= req_byte;
        addr_lsb_q <= req_addr[0];
      end
      if (accept && !misaligned) begin
        mem_addr  <= {1'b0, req_addr[ADDR_W-1:1]};
        mem_wdata <= wdata_fmt;
      end
      req_ready  <= (next_state == IDLE);
      resp_valid <= (next_state == DONE);
      mem_ce_n   <= !nxt_active;
      mem_oe_n   <= !((next_state == ACCESS) && !nxt_write);
      mem_we_n   <= !((next_state == ACCESS) && nxt_write);
      mem_ub_n   <= !(nxt_active && nxt_lane[1]);
      mem_lb_n   <= !(nxt_active && nxt_lane[0]);
      mem_drive  <= nxt_active && nxt_write;
      // IDLE straight to DONE only happens for a misaligned word request.
      if (next_state == DONE) begin
        resp_err <= (state == IDLE);
        if (state == IDLE) begin
          resp_rdata <= '0;
        end else if (!write_q) begin
          resp_rdata <= rdata_fmt;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - self-checking bench for mem_access_unit
module tb_mem_access_unit;

  localparam int W0 = 2;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  logic        req_valid, req_ready, req_write, req_byte;
  logic [19:0] req_addr, mem_addr;
  logic [15:0] req_wdata, resp_rdata, mem_wdata, mem_rdata;
  logic        resp_valid, resp_err, mem_ce_n, mem_oe_n, mem_we_n, mem_ub_n, mem_lb_n, mem_drive;

  logic        req_valid1, req_ready1, req_write1, req_byte1;
  logic [19:0] req_addr1, mem_addr1;
  logic [15:0] req_wdata1, resp_rdata1, mem_wdata1, mem_rdata1;
  logic        resp_valid1, resp_err1, mem_ce_n1, mem_oe_n1, mem_we_n1, mem_ub_n1, mem_lb_n1, mem_drive1;

  mem_access_unit #(.DATA_W(16), .ADDR_W(20), .WAIT_CYCLES(W0)) dut (
    .Clk(Clk), .Reset(Reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_byte(req_byte), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .mem_addr(mem_addr), .mem_ce_n(mem_ce_n), .mem_oe_n(mem_oe_n), .mem_we_n(mem_we_n),
    .mem_ub_n(mem_ub_n), .mem_lb_n(mem_lb_n), .mem_wdata(mem_wdata), .mem_drive(mem_drive),
    .mem_rdata(mem_rdata)
  );

  mem_access_unit #(.DATA_W(16), .ADDR_W(20), .WAIT_CYCLES(0)) dut1 (
    .Clk(Clk), .Reset(Reset), .req_valid(req_valid1), .req_ready(req_ready1),
    .req_write(req_write1), .req_byte(req_byte1), .req_addr(req_addr1), .req_wdata(req_wdata1),
    .resp_valid(resp_valid1), .resp_err(resp_err1), .resp_rdata(resp_rdata1),
    .mem_addr(mem_addr1), .mem_ce_n(mem_ce_n1), .mem_oe_n(mem_oe_n1), .mem_we_n(mem_we_n1),
    .mem_ub_n(mem_ub_n1), .mem_lb_n(mem_lb_n1), .mem_wdata(mem_wdata1), .mem_drive(mem_drive1),
    .mem_rdata(mem_rdata1)
  );

  // Behavioural SRAM: lower lane holds the even byte of each word.
  logic [15:0] sram [64];
  assign mem_rdata  = (!mem_ce_n && !mem_oe_n) ? sram[mem_addr[5:0]] : 16'hDEAD;
  assign mem_rdata1 = (!mem_ce_n1 && !mem_oe_n1) ? 16'hC0DE : 16'hDEAD;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic sram_obs();
    if (!mem_ce_n && !mem_we_n && mem_drive) begin
      if (!mem_lb_n) sram[mem_addr[5:0]][7:0]  = mem_wdata[7:0];
      if (!mem_ub_n) sram[mem_addr[5:0]][15:8] = mem_wdata[15:8];
    end
  endtask

  typedef struct {
    int          resp_cyc, ce_cyc, oe_cyc, we_cyc, drv_cyc, proto_bad;
    logic [15:0] rdata, wdat;
    logic        err, ub_n, lb_n;
    logic [19:0] maddr;
  } obs_t;

  // Drives one request on dut and checks the cycle-by-cycle timeline:
  // SETUP in cycle 1, ACCESS in cycles 2..W0+2, DONE in W0+3 (misaligned: DONE in cycle 1).
  task automatic run_txn(input logic w, input logic b, input logic [19:0] a,
                         input logic [15:0] wd, input bit noise, output obs_t o);
    bit e_err, e_ce, e_oe, e_we;
    int last;
    o.resp_cyc = -1; o.ce_cyc = 0; o.oe_cyc = 0; o.we_cyc = 0; o.drv_cyc = 0; o.proto_bad = 0;
    o.rdata = 16'hDEAD; o.wdat = 16'h0; o.err = 1'b0; o.ub_n = 1'b1; o.lb_n = 1'b1; o.maddr = 20'h0;
    e_err = !b && a[0];
    last  = e_err ? 1 : W0 + 3;
    if (req_ready !== 1'b1) o.proto_bad++;
    req_valid = 1'b1; req_write = w; req_byte = b; req_addr = a; req_wdata = wd;
    step();
    for (int c = 1; c <= last; c++) begin
      e_ce = !e_err && (c <= W0 + 2);
      e_oe = e_ce && (c >= 2) && !w;
      e_we = e_ce && (c >= 2) && w;
      if ({mem_ce_n, mem_oe_n, mem_we_n, mem_drive, resp_valid, req_ready} !==
          {!e_ce, !e_oe, !e_we, e_ce && w, c == last, 1'b0})
        o.proto_bad++;
      if (!mem_ce_n) begin
        o.ce_cyc++; o.maddr = mem_addr; o.ub_n = mem_ub_n; o.lb_n = mem_lb_n;
      end
      if (!mem_oe_n) o.oe_cyc++;
      if (!mem_we_n) o.we_cyc++;
      if (mem_drive) begin o.drv_cyc++; o.wdat = mem_wdata; end
      if (resp_valid && o.resp_cyc < 0) begin
        o.resp_cyc = c; o.rdata = resp_rdata; o.err = resp_err;
      end
      sram_obs();
      if (noise && c < last) begin
        req_valid = 1'b1; req_write = 1'($urandom); req_byte = 1'($urandom);
        req_addr = 20'($urandom); req_wdata = 16'($urandom);
      end else begin
        req_valid = 1'b0;
      end
      step();
    end
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) o.proto_bad++;
  endtask

  typedef struct {
    logic        w, b;
    logic [19:0] addr;
    logic [15:0] wdata, pre, post, rdata;
    logic        err;
    int          cyc, ce, oe, we, drv;
    logic [19:0] maddr;
    logic        ub_n, lb_n;
    logic [15:0] wdat;
  } vec_t;

  vec_t vt[9];

  initial begin
    #1000000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

  initial begin
    obs_t        o;
    int          idx, ai, resp_cnt;
    int          acc[$], rsp[$];
    logic [15:0] rsp_data[$];
    logic        rsp_err_seen;
    logic        w, b, e_err;
    logic [19:0] a;
    logic [15:0] wd, exp_rd;
    logic [7:0]  shadow [128];

    //            w     b     addr        wdata     pre       post      rdata     err  cyc ce oe we drv maddr       ub    lb    wdat
    vt[0] = '{1'b0, 1'b0, 20'h00010, 16'h0000, 16'hBEEF, 16'hBEEF, 16'hBEEF, 1'b0, 5, 4, 3, 0, 0, 20'h00008, 1'b0, 1'b0, 16'h0000};
    vt[1] = '{1'b1, 1'b1, 20'h00021, 16'h12AB, 16'h0000, 16'hAB00, 16'h0000, 1'b0, 5, 4, 0, 3, 4, 20'h00010, 1'b0, 1'b1, 16'hABAB};
    vt[2] = '{1'b0, 1'b1, 20'h00020, 16'h0000, 16'h80F7, 16'h80F7, 16'h00F7, 1'b0, 5, 4, 3, 0, 0, 20'h00010, 1'b1, 1'b0, 16'h0000};
    vt[3] = '{1'b0, 1'b1, 20'h00021, 16'h0000, 16'h80F7, 16'h80F7, 16'h0080, 1'b0, 5, 4, 3, 0, 0, 20'h00010, 1'b0, 1'b1, 16'h0000};
    vt[4] = '{1'b0, 1'b0, 20'h00003, 16'h0000, 16'h4444, 16'h4444, 16'h0000, 1'b1, 1, 0, 0, 0, 0, 20'h00000, 1'b1, 1'b1, 16'h0000};
    vt[5] = '{1'b1, 1'b0, 20'h0003E, 16'h5A3C, 16'hFFFF, 16'h5A3C, 16'h0000, 1'b0, 5, 4, 0, 3, 4, 20'h0001F, 1'b0, 1'b0, 16'h5A3C};
    vt[6] = '{1'b0, 1'b0, 20'hFFFFE, 16'h0000, 16'h1234, 16'h1234, 16'h1234, 1'b0, 5, 4, 3, 0, 0, 20'h7FFFF, 1'b0, 1'b0, 16'h0000};
    vt[7] = '{1'b1, 1'b0, 20'h00101, 16'h9999, 16'h7777, 16'h7777, 16'h0000, 1'b1, 1, 0, 0, 0, 0, 20'h00000, 1'b1, 1'b1, 16'h0000};
    vt[8] = '{1'b1, 1'b1, 20'h00020, 16'h00C3, 16'h1111, 16'h11C3, 16'h0000, 1'b0, 5, 4, 0, 3, 4, 20'h00010, 1'b1, 1'b0, 16'hC3C3};

    for (int i = 0; i < 64; i++) sram[i] = 16'h0;
    req_valid = 1'b0; req_write = 1'b0; req_byte = 1'b0; req_addr = 20'h0; req_wdata = 16'h0;
    req_valid1 = 1'b0; req_write1 = 1'b0; req_byte1 = 1'b0; req_addr1 = 20'h0; req_wdata1 = 16'h0;

    Reset = 1'b1;
    step();
    step();
    chk("reset ctrl", 32'({req_ready, resp_valid, resp_err, mem_ce_n, mem_oe_n, mem_we_n,
                           mem_ub_n, mem_lb_n, mem_drive}), 32'(9'b100_11111_0));
    chk("reset data", 32'({resp_rdata, mem_wdata}), 32'h0);
    chk("reset mem_addr", 32'(mem_addr), 32'h0);
    chk("reset ctrl w0", 32'({req_ready1, resp_valid1, resp_err1, mem_ce_n1, mem_oe_n1, mem_we_n1,
                              mem_ub_n1, mem_lb_n1, mem_drive1}), 32'(9'b100_11111_0));
    Reset = 1'b0;
    step();

    for (int i = 0; i < 9; i++) begin
      idx = int'(vt[i].addr[6:1]);
      sram[idx] = vt[i].pre;
      run_txn(vt[i].w, vt[i].b, vt[i].addr, vt[i].wdata, 1'b0, o);
      chk($sformatf("row%0d err", i), 32'(o.err), 32'(vt[i].err));
      chk($sformatf("row%0d resp_cycle", i), 32'(o.resp_cyc), 32'(vt[i].cyc));
      chk($sformatf("row%0d ce_cycles", i), 32'(o.ce_cyc), 32'(vt[i].ce));
      chk($sformatf("row%0d oe_cycles", i), 32'(o.oe_cyc), 32'(vt[i].oe));
      chk($sformatf("row%0d we_cycles", i), 32'(o.we_cyc), 32'(vt[i].we));
      chk($sformatf("row%0d drive_cycles", i), 32'(o.drv_cyc), 32'(vt[i].drv));
      chk($sformatf("row%0d lanes", i), 32'({o.ub_n, o.lb_n}), 32'({vt[i].ub_n, vt[i].lb_n}));
      chk($sformatf("row%0d timeline", i), 32'(o.proto_bad), 32'h0);
      chk($sformatf("row%0d sram_after", i), 32'(sram[idx]), 32'(vt[i].post));
      if (!vt[i].w || vt[i].err) chk($sformatf("row%0d rdata", i), 32'(o.rdata), 32'(vt[i].rdata));
      if (!vt[i].err) chk($sformatf("row%0d mem_addr", i), 32'(o.maddr), 32'(vt[i].maddr));
      if (vt[i].w && !vt[i].err) chk($sformatf("row%0d mem_wdata", i), 32'(o.wdat), 32'(vt[i].wdat));
    end

    // Reset in the middle of a read's ACCESS phase must abandon it silently.
    req_valid = 1'b1; req_write = 1'b0; req_byte = 1'b0; req_addr = 20'h00010;
    step();
    req_valid = 1'b0;
    step();
    step();
    chk("midreset oe before", 32'(mem_oe_n), 32'h0);
    Reset = 1'b1;
    step();
    chk("midreset strobes", 32'({mem_ce_n, mem_oe_n, mem_we_n, mem_ub_n, mem_lb_n, mem_drive, req_ready}),
        32'(7'b11111_0_1));
    Reset = 1'b0;
    resp_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (resp_valid) resp_cnt++;
      step();
    end
    chk("midreset no resp", 32'(resp_cnt), 32'h0);

    // Zero-wait build with req_valid held: accepts every 4 cycles, response 3 after accept.
    req_valid1 = 1'b1; req_write1 = 1'b0; req_byte1 = 1'b0; req_addr1 = 20'h00040;
    rsp_err_seen = 1'b0;
    for (int i = 0; i < 14; i++) begin
      if (req_ready1) acc.push_back(i);
      if (resp_valid1) begin
        rsp.push_back(i);
        rsp_data.push_back(resp_rdata1);
        if (resp_err1) rsp_err_seen = 1'b1;
      end
      step();
    end
    req_valid1 = 1'b0;
    chk("b2b accept count", 32'(acc.size()), 32'd4);
    chk("b2b resp count", 32'(rsp.size()), 32'd3);
    chk("b2b resp_err", 32'(rsp_err_seen), 32'h0);
    for (int k = 0; k < 3; k++) begin
      if (k < acc.size()) chk($sformatf("b2b accept%0d cycle", k), 32'(acc[k]), 32'(4 * k));
      if (k < rsp.size() && k < acc.size())
        chk($sformatf("b2b resp%0d latency", k), 32'(rsp[k] - acc[k]), 32'd3);
      if (k < rsp_data.size()) chk($sformatf("b2b resp%0d rdata", k), 32'(rsp_data[k]), 32'h0000C0DE);
    end
    for (int i = 0; i < 6; i++) step();

    // Random traffic against a byte-array model of memory.
    for (int i = 0; i < 128; i++) shadow[i] = 8'($urandom);
    for (int i = 0; i < 64; i++) sram[i] = {shadow[2 * i + 1], shadow[2 * i]};
    for (int n = 0; n < 80; n++) begin
      w  = 1'($urandom);
      b  = 1'($urandom);
      a  = 20'($urandom_range(0, 127));
      wd = 16'($urandom);
      ai = int'(a);
      e_err = !b && a[0];
      if (e_err)  exp_rd = 16'h0000;
      else if (b) exp_rd = {8'h00, shadow[ai]};
      else        exp_rd = {shadow[ai + 1], shadow[ai]};
      run_txn(w, b, a, wd, n[0], o);
      chk($sformatf("rnd%0d err", n), 32'(o.err), 32'(e_err));
      chk($sformatf("rnd%0d timeline", n), 32'(o.proto_bad), 32'h0);
      if (!w || e_err) chk($sformatf("rnd%0d rdata", n), 32'(o.rdata), 32'(exp_rd));
      if (!e_err) chk($sformatf("rnd%0d mem_addr", n), 32'(o.maddr), 32'(a >> 1));
      if (w && !e_err) begin
        shadow[ai] = wd[7:0];
        if (!b) shadow[ai + 1] = wd[15:8];
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
